piso_stream: RTL

PISO_STREAM -- requirements
Module: piso_stream

---
 rtl/piso_stream_pkg.sv | 18 +
 rtl/piso_stream_if.sv | 45 ++++
 rtl/piso_stream.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/piso_stream_pkg.sv
// -----------------------------------------------------------------------------
// piso_stream_pkg
//   Shared constants and helpers for the parallel-in / serial-out stream block.
//   DATA_WIDTH is the project-wide data width; the serializer's parallel word
//   defaults to twice this value.
// -----------------------------------------------------------------------------
package piso_stream_pkg;

  // Project-wide base data width.
  localparam int DATA_WIDTH = 4;

  // Width of a counter that must index n beats (0..n-1), never narrower
  // than one bit so that the n == 1 case still has a legal vector.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage : piso_stream_pkg

// File: rtl/piso_stream_if.sv
// -----------------------------------------------------------------------------
// piso_stream_if
//   Bundles both handshakes of the serializer.
//   Input side  : in_valid, in_ready, in_data  (PAR_WIDTH bits)
//   Output side : out_valid, out_ready, out_data (SER_WIDTH bits), out_last
//   Modports:
//     master - the environment: drives the parallel word, consumes beats
//     slave  - the serializer: accepts parallel words, produces beats
// -----------------------------------------------------------------------------
interface piso_stream_if
  import piso_stream_pkg::*;
#(
  parameter int PAR_WIDTH = DATA_WIDTH * 2,
  parameter int SER_WIDTH = 1
);

  logic                 in_valid;
  logic                 in_ready;
  logic [PAR_WIDTH-1:0] in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [SER_WIDTH-1:0] out_data;
  logic                 out_last;

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_last
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output out_last
  );

endinterface : piso_stream_if

// File: rtl/piso_stream.sv
// -----------------------------------------------------------------------------
// piso_stream
//   Parallel-in / serial-out stream converter with a one-word skid/hold
//   register, so a new word can be accepted while the current one is still
//   being shifted out. With out_ready held high, words stream back-to-back
//   with no idle beat between them.
//
//   Parameters
//     PAR_WIDTH : parallel word width (integer multiple of SER_WIDTH)
//     SER_WIDTH : bits per output beat
//     MSB_FIRST : 0 = least-significant slice first, 1 = most-significant first
//
//   Ports
//     clk   : clock, all state on the rising edge
//     rst_n : asynchronous active-low reset
//     bus   : piso_stream_if slave (in_* handshake in, out_* handshake out)
//     busy  : a word is being emitted or is waiting in the hold register
// -----------------------------------------------------------------------------
module piso_stream
  import piso_stream_pkg::*;
#(
  parameter int PAR_WIDTH = DATA_WIDTH * 2,
  parameter int SER_WIDTH = 1,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  piso_stream_if.slave      bus,
  output logic              busy
);

  // Beats per word and the beat-counter geometry.
  localparam int                BEATS    = PAR_WIDTH / SER_WIDTH;
  localparam int                CNT_W    = cnt_width(BEATS);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(BEATS - 1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [PAR_WIDTH-1:0] shifter_reg,    shifter_next;
  logic [CNT_W-1:0]     cnt_reg,        cnt_next;
  logic [PAR_WIDTH-1:0] hold_reg,       hold_next;
  logic                 hold_valid_reg, hold_valid_next;
  logic                 out_valid_reg,  out_valid_next;

  // ---------------------------------------------------------------------------
  // Handshake decode
  // ---------------------------------------------------------------------------
  logic                 accept;
  logic                 beat;
  logic                 at_last;
  logic                 load;
  logic                 direct_load;
  logic [PAR_WIDTH-1:0] shifted;
  logic [SER_WIDTH-1:0] slice;

  assign at_last = (cnt_reg == LAST_CNT);
  assign accept  = bus.in_valid && !hold_valid_reg;
  assign beat    = out_valid_reg && bus.out_ready;

  // The shifter is free either because it is empty or because its final
  // beat is leaving on this edge.
  assign load = !out_valid_reg || (beat && at_last);

  // A freshly accepted word bypasses the hold register only when the shifter
  // is free and nothing older is waiting ahead of it.
  assign direct_load = load && !hold_valid_reg && accept;

  // ---------------------------------------------------------------------------
  // Slice selection and shift direction
  // ---------------------------------------------------------------------------
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign slice   = shifter_reg[PAR_WIDTH-1 -: SER_WIDTH];
      assign shifted = shifter_reg << SER_WIDTH;
    end else begin : g_lsb_first
      assign slice   = shifter_reg[SER_WIDTH-1:0];
      assign shifted = shifter_reg >> SER_WIDTH;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    shifter_next    = shifter_reg;
    cnt_next        = cnt_reg;
    hold_next       = hold_reg;
    hold_valid_next = hold_valid_reg;
    out_valid_next  = out_valid_reg;

    if (load) begin
      if (hold_valid_reg) begin
        // Oldest word first: drain the hold register into the shifter.
        shifter_next    = hold_reg;
        cnt_next        = '0;
        out_valid_next  = 1'b1;
        hold_valid_next = 1'b0;
      end else if (accept) begin
        shifter_next   = bus.in_data;
        cnt_next       = '0;
        out_valid_next = 1'b1;
      end else begin
        // Nothing to send: go idle with a clean shifter so out_data reads 0.
        shifter_next   = '0;
        cnt_next       = '0;
        out_valid_next = 1'b0;
      end
    end else if (beat) begin
      shifter_next = shifted;
      cnt_next     = cnt_reg + CNT_W'(1);
    end

    // Any accepted word that did not go straight to the shifter is parked.
    if (accept && !direct_load) begin
      hold_next       = bus.in_data;
      hold_valid_next = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shifter_reg    <= '0;
      cnt_reg        <= '0;
      hold_reg       <= '0;
      hold_valid_reg <= 1'b0;
      out_valid_reg  <= 1'b0;
    end else begin
      shifter_reg    <= shifter_next;
      cnt_reg        <= cnt_next;
      hold_reg       <= hold_next;
      hold_valid_reg <= hold_valid_next;
      out_valid_reg  <= out_valid_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.in_ready  = !hold_valid_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.out_data  = slice;
  assign bus.out_last  = out_valid_reg && at_last;
  assign busy          = out_valid_reg || hold_valid_reg;

endmodule : piso_stream
